// File: rtl/bcd3_display_scan_pkg.sv
// Shared constants for the three-digit BCD display scanner: digit indices,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and bus widths.
package uth_pkg;

  localparam int SEG_W = 7;
  localparam int DIG_N = 3;

  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {
    PTR_UNITS    = 2'd0,
    PTR_TENS     = 2'd1,
    PTR_HUNDREDS = 2'd2
  } ptr_e;

endpackage

// File: rtl/bcd3_display_scan_if.sv
// Digit inputs from the BCD counter and multiplexed display pins.
// The scanner connects through the slave modport.
interface bcd3_display_scan_if;
  import uth_pkg::*;

  logic [3:0]       units;
  logic [3:0]       tens;
  logic [3:0]       hundreds;
  logic [SEG_W-1:0] seg;
  logic [DIG_N-1:0] an;
  logic             frame;
  logic             bad_digit;

  modport master (output units, tens, hundreds,
                  input  seg, an, frame, bad_digit);
  modport slave  (input  units, tens, hundreds,
                  output seg, an, frame, bad_digit);
endinterface

// File: rtl/bcd3_display_scan_bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; codes 10..15 show a dash
// and raise invalid_o.
module bcd_to_seg7
  import uth_pkg::*;
(
  input  logic [3:0]       digit_i,
  output logic [SEG_W-1:0] seg_o,
  output logic             invalid_o
);

  always_comb begin
    invalid_o = (digit_i > 4'd9);
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd3_display_scan.sv
// Three-digit multiplexed 7-segment scanner with per-frame coherent snapshot.
// Optional leading-zero blanking is enabled by defining UTH_BLANK_EN.
//
// state        | meaning
// PTR_UNITS    | units digit selected for the next display slot
// PTR_TENS     | tens digit selected
// PTR_HUNDREDS | hundreds digit selected; next tick wraps and loads snapshot
module bcd3_display_scan
  import uth_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                async_rst_n,
  bcd3_display_scan_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]               presc_q, presc_d;
  ptr_e                        ptr_q, ptr_d;
  logic [DIG_N-1:0][3:0]       snap_q, snap_d;
  logic [SEG_W-1:0]            seg_q, seg_d;
  logic [DIG_N-1:0]            an_q, an_d;
  logic                        upd_q, frame_q, bad_q, bad_d;
  logic                        tick, load, blank;
  logic [DIG_N-1:0][SEG_W-1:0] dec_seg;
  logic [DIG_N-1:0]            dec_inv;

  for (genvar g = 0; g < DIG_N; g++) begin : g_dec
    bcd_to_seg7 u_dec (
      .digit_i   (snap_q[g]),
      .seg_o     (dec_seg[g]),
      .invalid_o (dec_inv[g])
    );
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      presc_q <= '0;
      ptr_q   <= PTR_HUNDREDS;
      snap_q  <= '0;
      seg_q   <= '0;
      an_q    <= '0;
      upd_q   <= 1'b0;
      frame_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      upd_q   <= tick;
      frame_q <= load;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    ptr_d   = ptr_q;
    load    = 1'b0;
    if (tick) begin
      case (ptr_q)
        PTR_UNITS: ptr_d = PTR_TENS;
        PTR_TENS:  ptr_d = PTR_HUNDREDS;
        default: begin
          ptr_d = PTR_UNITS;
          load  = 1'b1;
        end
      endcase
    end
    snap_d = load ? {bus.hundreds, bus.tens, bus.units} : snap_q;

`ifdef UTH_BLANK_EN
    // Blanking looks only at the snapshot so a frame stays self-consistent.
    blank = ((ptr_q == PTR_HUNDREDS) && (snap_q[DIG_HUNDREDS] == 4'd0)) ||
            ((ptr_q == PTR_TENS) && (snap_q[DIG_HUNDREDS] == 4'd0) &&
             (snap_q[DIG_TENS] == 4'd0));
`else
    blank = 1'b0;
`endif

    // Outputs move one edge after the tick, once pointer and snapshot settled.
    seg_d = seg_q;
    an_d  = an_q;
    if (upd_q) begin
      if (blank) begin
        seg_d = '0;
        an_d  = '0;
      end else begin
        case (ptr_q)
          PTR_UNITS: begin
            seg_d = dec_seg[DIG_UNITS];
            an_d  = 3'b001;
          end
          PTR_TENS: begin
            seg_d = dec_seg[DIG_TENS];
            an_d  = 3'b010;
          end
          default: begin
            seg_d = dec_seg[DIG_HUNDREDS];
            an_d  = 3'b100;
          end
        endcase
      end
    end

    bad_d = bad_q | (frame_q & (|dec_inv));
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.frame     = frame_q;
  assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_bcd3_display_scan.sv
// Directed bench for bcd3_display_scan: SCAN_DIV=4 instance for timing,
// snapshot, bad-digit, reset and blanking; SCAN_DIV=1 instance for fast scan.
module tb_bcd3_display_scan;
  import uth_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n;
  int   tests  = 0;
  int   failed = 0;
  bit   blank_en;

  always #5 clk = ~clk;

  bcd3_display_scan_if ifa ();
  bcd3_display_scan_if ifb ();

  bcd3_display_scan #(.SCAN_DIV(4)) dut_a (
    .clk         (clk),
    .async_rst_n (rst_n),
    .bus         (ifa.slave)
  );

  bcd3_display_scan #(.SCAN_DIV(1)) dut_b (
    .clk         (clk),
    .async_rst_n (rst_n),
    .bus         (ifb.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (n < target) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic set_a(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    ifa.hundreds = h;
    ifa.tens     = t;
    ifa.units    = u;
  endtask

  initial begin
`ifdef UTH_BLANK_EN
    blank_en = 1'b1;
`else
    blank_en = 1'b0;
`endif
    n = 0;
    rst_n = 1'b0;
    set_a(4'd1, 4'd2, 4'd3);
    ifb.hundreds = 4'd4;
    ifb.tens     = 4'd5;
    ifb.units    = 4'd6;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", ifa.seg, 8'h00);
    chk("rst_an", ifa.an, 8'h0);
    chk("rst_frame", ifa.frame, 8'h0);
    chk("rst_bad", ifa.bad_digit, 8'h0);

    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    // SCAN_DIV=1 instance: 456, one digit per cycle, frame every third edge
    step_to(1);
    chk("b_frame1", ifb.frame, 8'h1);
    chk("a_frame1", ifa.frame, 8'h0);
    step_to(2);
    chk("b_seg2", ifb.seg, 8'h7D);
    chk("b_an2", ifb.an, 8'h1);
    chk("b_frame2", ifb.frame, 8'h0);
    step_to(3);
    chk("b_seg3", ifb.seg, 8'h6D);
    chk("b_an3", ifb.an, 8'h2);
    chk("b_frame3", ifb.frame, 8'h0);
    chk("a_frame3", ifa.frame, 8'h0);
    step_to(4);
    chk("b_seg4", ifb.seg, 8'h66);
    chk("b_an4", ifb.an, 8'h4);
    chk("b_frame4", ifb.frame, 8'h1);
    chk("a_frame4", ifa.frame, 8'h1);
    chk("a_an4_still0", ifa.an, 8'h0);
    step_to(5);
    chk("b_seg5", ifb.seg, 8'h7D);
    chk("b_an5", ifb.an, 8'h1);
    chk("a_seg5", ifa.seg, 8'h4F);
    chk("a_an5", ifa.an, 8'h1);
    chk("a_frame5", ifa.frame, 8'h0);
    step_to(7);
    chk("b_frame7", ifb.frame, 8'h1);
    step_to(8);
    chk("a_seg8_hold", ifa.seg, 8'h4F);
    chk("a_an8_hold", ifa.an, 8'h1);
    step_to(9);
    chk("a_seg9", ifa.seg, 8'h5B);
    chk("a_an9", ifa.an, 8'h2);
    step_to(13);
    chk("a_seg13", ifa.seg, 8'h06);
    chk("a_an13", ifa.an, 8'h4);
    step_to(16);
    chk("a_frame16", ifa.frame, 8'h1);
    step_to(17);
    chk("a_seg17", ifa.seg, 8'h4F);
    chk("a_an17", ifa.an, 8'h1);

    // 099 snapshotted at edge 28, rolls to 100 mid tens slot
    set_a(4'd0, 4'd9, 4'd9);
    step_to(29);
    chk("nt_u_seg", ifa.seg, 8'h6F);
    step_to(33);
    chk("nt_t_seg", ifa.seg, 8'h6F);
    chk("nt_t_an", ifa.an, 8'h2);
    step_to(35);
    set_a(4'd1, 4'd0, 4'd0);
    step_to(36);
    chk("nt_t_hold", ifa.seg, 8'h6F);
    step_to(37);
    chk("nt_h_seg", ifa.seg, blank_en ? 8'h00 : 8'h3F);
    chk("nt_h_an", ifa.an, blank_en ? 8'h0 : 8'h4);
    step_to(41);
    chk("nx_u_seg", ifa.seg, 8'h3F);
    chk("nx_u_an", ifa.an, 8'h1);
    step_to(45);
    chk("nx_t_seg", ifa.seg, 8'h3F);
    chk("nx_t_an", ifa.an, 8'h2);
    step_to(49);
    chk("nx_h_seg", ifa.seg, 8'h06);
    chk("nx_h_an", ifa.an, 8'h4);

    // units = 12 at snapshot edge 52
    set_a(4'd1, 4'd0, 4'd12);
    step_to(52);
    chk("bad_before", ifa.bad_digit, 8'h0);
    step_to(53);
    chk("bad_set", ifa.bad_digit, 8'h1);
    chk("dash_seg", ifa.seg, 8'h40);
    chk("dash_an", ifa.an, 8'h1);
    set_a(4'd1, 4'd2, 4'd3);
    step_to(65);
    chk("bad_sticky", ifa.bad_digit, 8'h1);
    chk("valid_seg65", ifa.seg, 8'h4F);

    // asynchronous reset in the middle of the tens slot
    step_to(70);
    chk("pre_rst_an", ifa.an, 8'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", ifa.seg, 8'h00);
    chk("arst_an", ifa.an, 8'h0);
    chk("arst_frame", ifa.frame, 8'h0);
    chk("arst_bad", ifa.bad_digit, 8'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_an", ifa.an, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    step_to(3);
    chk("re_frame3", ifa.frame, 8'h0);
    step_to(4);
    chk("re_frame4", ifa.frame, 8'h1);
    chk("re_an4", ifa.an, 8'h0);
    step_to(5);
    chk("re_seg5", ifa.seg, 8'h4F);
    chk("re_an5", ifa.an, 8'h1);
    step_to(9);
    chk("re_seg9", ifa.seg, 8'h5B);
    chk("re_an9", ifa.an, 8'h2);

    // 007 loaded at edge 16: leading zeros shown or blanked
    set_a(4'd0, 4'd0, 4'd7);
    step_to(17);
    chk("z_u_seg", ifa.seg, 8'h07);
    chk("z_u_an", ifa.an, 8'h1);
    step_to(21);
    chk("z_t_seg", ifa.seg, blank_en ? 8'h00 : 8'h3F);
    chk("z_t_an", ifa.an, blank_en ? 8'h0 : 8'h2);
    step_to(25);
    chk("z_h_seg", ifa.seg, blank_en ? 8'h00 : 8'h3F);
    chk("z_h_an", ifa.an, blank_en ? 8'h0 : 8'h4);
    chk("z_bad", ifa.bad_digit, 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
